// File: rtl/vdg_pkg.sv
// rtl/vdg_pkg.sv - shared VDG defaults and the character attribute-combine rule
package vdg_pkg;

   localparam int WIDTH_DEF     = 8;
   localparam int BLINK_DIV_DEF = 16;

   typedef struct packed {
      logic inv;
      logic blink;
      logic cursor;
   } attr_t;

   // The cursor flips video on the lit blink phase, on top of the cell's own inverse bit.
   function automatic logic attr_eff_inv(input attr_t attr, input logic phase);
      return attr.inv ^ (attr.cursor & phase);
   endfunction

   // Per-pixel form so any pattern width (or the semigraphics path) can reuse it.
   function automatic logic attr_bit(input logic d, input attr_t attr, input logic phase);
      logic pat;
      pat = d & ~(attr.blink & phase);
      return pat ^ attr_eff_inv(attr, phase);
   endfunction

endpackage

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - field-sync driven blink divider producing the blink phase
module blink_gen #(
   parameter int BLINK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic fsync,
   input  logic blink_en,
   output logic phase
);

   localparam int CNT_W = $clog2(BLINK_DIV);

   logic             fsync_q;
   logic             fsync_rise;
   logic [CNT_W-1:0] cnt;

   // A held-high sync level counts once: only the rising edge advances the divider.
   assign fsync_rise = fsync & ~fsync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsync_q <= 1'b0;
         cnt     <= '0;
         phase   <= 1'b0;
      end else begin
         fsync_q <= fsync;
         if (!blink_en) begin
            cnt   <= '0;
            phase <= 1'b0;
         end else if (fsync_rise) begin
            if (cnt == CNT_W'(BLINK_DIV - 1)) begin
               cnt   <= '0;
               phase <= ~phase;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/alpha_pixel_shifter.sv
// rtl/alpha_pixel_shifter.sv - attributed character-row latch and pixel serialiser
module alpha_pixel_shifter
   import vdg_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int BLINK_DIV = BLINK_DIV_DEF
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             PixEn,
   input  logic             Load,
   input  logic [WIDTH-1:0] Data,
   input  logic             Inv,
   input  logic             Blink,
   input  logic             Cursor,
   input  logic             BlinkEn,
   input  logic             FSync,
   output logic             Pixel,
   output logic [WIDTH-1:0] AData,
   output logic             BlinkPhase,
   output logic             Empty
);

   localparam int SC_W = $clog2(WIDTH + 1);

   attr_t            attr;
   logic [WIDTH-1:0] adata_next;
   logic             bg_next;
   logic [WIDTH-1:0] sreg;
   logic             bg;
   logic [SC_W-1:0]  scnt;
   logic             empty_q;

   assign attr    = {Inv, Blink, Cursor};
   assign bg_next = attr_eff_inv(attr, BlinkPhase);

   for (genvar i = 0; i < WIDTH; i++) begin : g_attr
      assign adata_next[i] = attr_bit(Data[i], attr, BlinkPhase);
   end

   blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk      (Clk),
      .rst_n    (nReset),
      .fsync    (FSync),
      .blink_en (BlinkEn),
      .phase    (BlinkPhase)
   );

   // Vacated bits fill with the cell background so an over-run never shows stale pattern.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sreg    <= '0;
         AData   <= '0;
         bg      <= 1'b0;
         scnt    <= '0;
         empty_q <= 1'b1;
      end else if (Load) begin
         sreg    <= adata_next;
         AData   <= adata_next;
         bg      <= bg_next;
         scnt    <= SC_W'(WIDTH);
         empty_q <= 1'b0;
      end else if (PixEn) begin
         sreg <= {sreg[WIDTH-2:0], bg};
         if (scnt != '0) begin
            scnt <= scnt - SC_W'(1);
            if (scnt == SC_W'(1)) begin
               empty_q <= 1'b1;
            end
         end
      end
   end

   assign Pixel = sreg[WIDTH-1];
   assign Empty = empty_q;

endmodule

// File: tb/tb_alpha_pixel_shifter.sv
// tb/tb_alpha_pixel_shifter.sv - self-checking bench for alpha_pixel_shifter
module tb_alpha_pixel_shifter;

   localparam int W  = 8;
   localparam int BD = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pixen = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] data = '0;
   logic         inv = 1'b0;
   logic         blink = 1'b0;
   logic         cursor = 1'b0;
   logic         blinken = 1'b0;
   logic         fsync = 1'b0;
   logic         pixel;
   logic [W-1:0] adata;
   logic         phase;
   logic         empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alpha_pixel_shifter #(
      .WIDTH     (W),
      .BLINK_DIV (BD)
   ) dut (
      .Clk        (clk),
      .nReset     (rst_n),
      .PixEn      (pixen),
      .Load       (load),
      .Data       (data),
      .Inv        (inv),
      .Blink      (blink),
      .Cursor     (cursor),
      .BlinkEn    (blinken),
      .FSync      (fsync),
      .Pixel      (pixel),
      .AData      (adata),
      .BlinkPhase (phase),
      .Empty      (empty)
   );

   // Reference: the loaded row is a queue of pixels still to be shown, the blink is a plain counter.
   bit           m_q[$];
   bit           m_bg;
   bit [W-1:0]   m_adata;
   bit           m_phase;
   int           m_cnt;
   bit           m_fprev;

   function automatic void model_reset();
      m_q.delete();
      m_bg = 0; m_adata = '0; m_phase = 0; m_cnt = 0; m_fprev = 0;
   endfunction

   function automatic void model_edge();
      bit [W-1:0] pat;
      bit         ei;
      if (load) begin
         ei      = inv ^ (cursor & m_phase);
         pat     = (blink && m_phase) ? '0 : data;
         m_adata = ei ? ~pat : pat;
         m_bg    = ei;
         m_q.delete();
         for (int i = W - 1; i >= 0; i--) m_q.push_back(m_adata[i]);
      end else if (pixen && m_q.size() > 0) begin
         void'(m_q.pop_front());
      end
      if (!blinken) begin
         m_cnt = 0; m_phase = 0;
      end else if (fsync && !m_fprev) begin
         m_cnt++;
         if (m_cnt == BD) begin m_cnt = 0; m_phase = !m_phase; end
      end
      m_fprev = fsync;
   endfunction

   function automatic bit m_pixel();
      return (m_q.size() > 0) ? m_q[0] : m_bg;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      fsync = 1'b1; step();
      fsync = 1'b0; step();
   endtask

   typedef struct {
      logic         ld;
      logic         pe;
      logic [W-1:0] d;
      logic         iv;
      logic         ep;
      logic         ee;
      logic [W-1:0] ea;
   } vec_t;

   vec_t vt[$];

   initial begin
      logic [W-1:0] pa, pc, pm, pn;

      pa = 8'hA5; pc = 8'hC3; pm = 8'h5A; pn = 8'h81;
      vt.push_back('{1'b1, 1'b0, pa, 1'b0, 1'b1, 1'b0, pa});
      for (int k = 1; k < W; k++) vt.push_back('{1'b0, 1'b1, '0, 1'b0, pa[W-1-k], 1'b0, pa});
      vt.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, pa});
      vt.push_back('{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, pc});
      for (int k = 1; k < W; k++) vt.push_back('{1'b0, 1'b1, '0, 1'b0, pc[W-1-k], 1'b0, pc});
      for (int k = 0; k < 3; k++) vt.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, pc});
      vt.push_back('{1'b1, 1'b0, pm, 1'b0, 1'b0, 1'b0, pm});
      for (int k = 1; k <= 5; k++) vt.push_back('{1'b0, 1'b1, '0, 1'b0, pm[W-1-k], 1'b0, pm});
      vt.push_back('{1'b1, 1'b1, pn, 1'b0, 1'b1, 1'b0, pn});
      for (int k = 1; k < W; k++) vt.push_back('{1'b0, 1'b1, '0, 1'b0, pn[W-1-k], 1'b0, pn});
      vt.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, pn});

      #12;
      chk("reset pixel", pixel, 0);
      chk("reset adata", adata, 0);
      chk("reset phase", phase, 0);
      chk("reset empty", empty, 1);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (vt[i]) begin
         load = vt[i].ld; pixen = vt[i].pe; data = vt[i].d; inv = vt[i].iv;
         step();
         chk($sformatf("vec%0d pixel", i), pixel, vt[i].ep);
         chk($sformatf("vec%0d empty", i), empty, vt[i].ee);
         chk($sformatf("vec%0d adata", i), adata, vt[i].ea);
      end
      load = 1'b0; pixen = 1'b0; inv = 1'b0; data = '0;

      blinken = 1'b1; step();
      for (int p = 0; p < 3; p++) pulse();
      chk("blink after 3 pulses", phase, 0);
      fsync = 1'b1; step();
      chk("blink toggles on 4th edge", phase, 1);
      fsync = 1'b0; step();

      load = 1'b1; data = 8'hFF; blink = 1'b1; step();
      chk("blink blanks pattern", adata, 8'h00);
      blink = 1'b0; cursor = 1'b1; data = 8'h00; step();
      chk("cursor inverts cell", adata, 8'hFF);
      chk("cursor pixel", pixel, 1);
      load = 1'b0; cursor = 1'b0;

      fsync = 1'b1;
      repeat (10) step();
      fsync = 1'b0; step();
      chk("held fsync phase", phase, 1);
      pulse(); pulse();
      chk("held fsync counted once", phase, 1);
      pulse();
      chk("phase wraps after held", phase, 0);
      for (int p = 0; p < 4; p++) pulse();
      chk("phase high again", phase, 1);
      pulse();
      blinken = 1'b0; step();
      chk("blinken drop phase", phase, 0);
      blinken = 1'b1;
      for (int p = 0; p < 3; p++) pulse();
      chk("counter cleared by blinken", phase, 0);
      pulse();
      chk("full period after clear", phase, 1);

      load = 1'b1; data = 8'hFF; step();
      load = 1'b0; pixen = 1'b1; step(); step();
      pixen = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async reset pixel", pixel, 0);
      chk("async reset adata", adata, 0);
      chk("async reset phase", phase, 0);
      chk("async reset empty", empty, 1);
      rst_n = 1'b1;
      model_reset();
      pixen = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("post-reset pixel", pixel, 0);
         chk("post-reset empty", empty, 1);
      end

      for (int c = 0; c < 600; c++) begin
         load    = ($urandom % 7) == 0;
         pixen   = ($urandom % 3) != 0;
         data    = W'($urandom);
         inv     = 1'($urandom);
         blink   = 1'($urandom);
         cursor  = 1'($urandom);
         blinken = ($urandom % 50) != 0;
         fsync   = ($urandom % 3) == 0;
         step();
         chk("rand pixel", pixel, m_pixel());
         chk("rand empty", empty, m_q.size() == 0);
         chk("rand adata", adata, m_adata);
         chk("rand phase", phase, m_phase);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
